// File: rtl/perceptron_predictor_spec.sv
// Perceptron conditional-branch predictor: registered prediction, speculative GHR, in-order
// outstanding-prediction FIFO and mispredict recovery. Define PERCEPTRON_STATS_EN for counters.
module perceptron_predictor_spec #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned HIST_LEN    = 8,
  parameter int unsigned WEIGHT_BITS = 8,
  parameter int unsigned TABLE_DEPTH = 256,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned THETA       = 29
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_req_ready,
  output logic                  o_pred_valid,
  output logic                  o_pred_taken,
  input  logic                  i_fb_valid,
  input  logic                  i_fb_outcome,
  output logic                  o_fb_error,
  output logic                  o_recover
`ifdef PERCEPTRON_STATS_EN
  ,
  output logic [31:0]           o_stat_preds,
  output logic [31:0]           o_stat_mispreds
`endif
);

  localparam int unsigned IdxBits = $clog2(TABLE_DEPTH);
  localparam int unsigned YBits   = WEIGHT_BITS + $clog2(HIST_LEN + 1);
  localparam int unsigned PtrBits = $clog2(FIFO_DEPTH);
  localparam logic [PtrBits:0] FullCnt = (PtrBits + 1)'(FIFO_DEPTH);

  typedef logic signed [WEIGHT_BITS-1:0] weight_t;
  typedef logic signed [YBits-1:0]       y_t;

  localparam weight_t WMax = {1'b0, {(WEIGHT_BITS - 1){1'b1}}};
  localparam weight_t WMin = {1'b1, {(WEIGHT_BITS - 1){1'b0}}};

  weight_t             w_q [TABLE_DEPTH][HIST_LEN+1];
  weight_t             row_new [HIST_LEN+1];
  logic [HIST_LEN-1:0] ghr_q, ghr_d;
  logic                pred_valid_q, pred_taken_q;

  logic [IdxBits-1:0]  fifo_idx_q  [FIFO_DEPTH];
  logic [HIST_LEN-1:0] fifo_ghr_q  [FIFO_DEPTH];
  y_t                  fifo_y_q    [FIFO_DEPTH];
  logic                fifo_pred_q [FIFO_DEPTH];
  logic [PtrBits-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrBits:0]    cnt_q;

  logic [IdxBits-1:0]  fold, req_idx, head_idx;
  logic [HIST_LEN-1:0] head_ghr;
  y_t                  y_sum, head_y;
  logic [YBits-1:0]    y_abs;
  logic                req_pred, head_pred, fifo_empty, fifo_full;
  logic                fb_live, mispredict, pop, req_ready, accept, train;

  logic unused_pc;
  assign unused_pc = ^{i_req_pc[ADDR_WIDTH-1:IdxBits+2], i_req_pc[1:0]};

  function automatic weight_t sat_step(weight_t w, logic up);
    if (up) return (w == WMax) ? w : w + weight_t'(1);
    return (w == WMin) ? w : w - weight_t'(1);
  endfunction

  // Prediction path: index hash and dot product on the current (pre-update) weights.
  always_comb begin
    fold = '0;
    for (int i = 0; i < int'(HIST_LEN); i++) fold[i % int'(IdxBits)] ^= ghr_q[i];
    req_idx = i_req_pc[IdxBits+1:2] ^ fold;
    y_sum = y_t'(w_q[req_idx][0]);
    for (int i = 1; i <= int'(HIST_LEN); i++) begin
      if (ghr_q[i-1]) y_sum = y_sum + y_t'(w_q[req_idx][i]);
      else            y_sum = y_sum - y_t'(w_q[req_idx][i]);
    end
    req_pred = ~y_sum[YBits-1];
  end

  always_comb begin
    head_idx   = fifo_idx_q[rd_ptr_q];
    head_ghr   = fifo_ghr_q[rd_ptr_q];
    head_y     = fifo_y_q[rd_ptr_q];
    head_pred  = fifo_pred_q[rd_ptr_q];
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FullCnt);
    fb_live    = i_fb_valid & ~fifo_empty;
    mispredict = fb_live & (i_fb_outcome != head_pred);
    pop        = fb_live & ~mispredict;
    // A same-cycle pop frees the slot, so a full FIFO can still take a request.
    req_ready  = ~fifo_full | pop;
    accept     = i_req_valid & req_ready & ~mispredict;
    y_abs      = head_y[YBits-1] ? -head_y : head_y;
    train      = fb_live & (mispredict | (32'(y_abs) <= THETA));
    row_new[0] = sat_step(w_q[head_idx][0], i_fb_outcome);
    for (int i = 1; i <= int'(HIST_LEN); i++) begin
      row_new[i] = sat_step(w_q[head_idx][i], head_ghr[i-1] == i_fb_outcome);
    end
    ghr_d = ghr_q;
    if (mispredict)  ghr_d = {head_ghr[HIST_LEN-2:0], i_fb_outcome};
    else if (accept) ghr_d = {ghr_q[HIST_LEN-2:0], req_pred};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= accept;
      pred_taken_q <= accept & req_pred;
      if (mispredict) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q <= cnt_q + {{PtrBits{1'b0}}, accept} - {{PtrBits{1'b0}}, pop};
      end
    end
  end

  // Entry payload needs no reset: it is only consumed while the count says it is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_idx_q[wr_ptr_q]  <= req_idx;
      fifo_ghr_q[wr_ptr_q]  <= ghr_q;
      fifo_y_q[wr_ptr_q]    <= y_sum;
      fifo_pred_q[wr_ptr_q] <= req_pred;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(TABLE_DEPTH); r++) begin
        for (int i = 0; i <= int'(HIST_LEN); i++) w_q[r][i] <= '0;
      end
    end else if (train) begin
      for (int i = 0; i <= int'(HIST_LEN); i++) w_q[head_idx][i] <= row_new[i];
    end
  end

`ifdef PERCEPTRON_STATS_EN
  logic [31:0] stat_preds_q, stat_mispreds_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_preds_q    <= '0;
      stat_mispreds_q <= '0;
    end else begin
      if (accept)     stat_preds_q    <= stat_preds_q + 32'd1;
      if (mispredict) stat_mispreds_q <= stat_mispreds_q + 32'd1;
    end
  end

  assign o_stat_preds    = stat_preds_q;
  assign o_stat_mispreds = stat_mispreds_q;
`endif

  assign o_req_ready  = req_ready;
  assign o_pred_valid = pred_valid_q;
  assign o_pred_taken = pred_taken_q;
  assign o_fb_error   = i_fb_valid & fifo_empty & ~rst;
  assign o_recover    = mispredict;

endmodule

// File: tb/tb_perceptron_predictor_spec.sv
// Bench for perceptron_predictor_spec: default DUT plus an always-training (large THETA) DUT
// driven in lockstep and checked every cycle against a list-based behavioural model.
module tb_perceptron_predictor_spec;

  localparam int Theta0 = 29;
  localparam int Theta1 = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_v, fb_v, fb_out;
  logic [31:0] req_pc;
  logic [1:0]  rdy, pv, pt, fbe, rec;

  always #5 clk = ~clk;

`ifdef PERCEPTRON_STATS_EN
  logic [31:0] stp0, stm0, stp1, stm1;
`endif

  perceptron_predictor_spec #(.THETA(Theta0)) dut0 (
    .clk(clk), .rst(rst), .i_req_valid(req_v), .i_req_pc(req_pc), .o_req_ready(rdy[0]),
    .o_pred_valid(pv[0]), .o_pred_taken(pt[0]), .i_fb_valid(fb_v), .i_fb_outcome(fb_out),
    .o_fb_error(fbe[0]), .o_recover(rec[0])
`ifdef PERCEPTRON_STATS_EN
    , .o_stat_preds(stp0), .o_stat_mispreds(stm0)
`endif
  );

  perceptron_predictor_spec #(.THETA(Theta1)) dut1 (
    .clk(clk), .rst(rst), .i_req_valid(req_v), .i_req_pc(req_pc), .o_req_ready(rdy[1]),
    .o_pred_valid(pv[1]), .o_pred_taken(pt[1]), .i_fb_valid(fb_v), .i_fb_outcome(fb_out),
    .o_fb_error(fbe[1]), .o_recover(rec[1])
`ifdef PERCEPTRON_STATS_EN
    , .o_stat_preds(stp1), .o_stat_mispreds(stm1)
`endif
  );

  typedef struct {
    int         idx;
    logic [7:0] g;
    int         y;
    bit         pred;
  } ent_t;

  int         mw [2][256][9];
  logic [7:0] mghr [2];
  ent_t       mq [2][8];
  int         mcnt [2];
  int         nrec [2];
  bit         exp_rdy [2], exp_fbe [2], exp_rec [2], exp_pv [2], exp_pt [2];
  bit         nxt_pv [2], nxt_pt [2];
  bit         chk_en = 1'b0;
  int         nchk = 0;
  int         nfail = 0;

  task automatic chk(input string name, input int m, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, m, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 256; r++) for (int i = 0; i < 9; i++) mw[m][r][i] = 0;
      mghr[m] = 8'h00; mcnt[m] = 0; nrec[m] = 0;
      exp_rdy[m] = 1; exp_fbe[m] = 0; exp_rec[m] = 0; exp_pv[m] = 0; exp_pt[m] = 0;
    end
  endtask

  // One cycle of spec behaviour for model instance m given this cycle's inputs.
  task automatic model_step(input int m, input bit req, input logic [31:0] pc, input bit fb,
                            input bit out);
    bit   mis, pop, acc, pred;
    int   idx, y, th, ay;
    ent_t h, e;
    th = (m == 0) ? Theta0 : Theta1;
    h = mq[m][0];
    exp_fbe[m] = fb && (mcnt[m] == 0);
    mis = fb && (mcnt[m] > 0) && (out != h.pred);
    pop = fb && (mcnt[m] > 0) && !mis;
    exp_rec[m] = mis;
    exp_rdy[m] = (mcnt[m] < 4) || pop;
    acc = req && exp_rdy[m] && !mis;
    idx = int'((pc >> 2) & 32'hFF) ^ int'(mghr[m]);
    y = mw[m][idx][0];
    for (int i = 1; i <= 8; i++) y += mghr[m][i-1] ? mw[m][idx][i] : -mw[m][idx][i];
    pred = (y >= 0);
    if (fb && mcnt[m] > 0) begin
      ay = (h.y < 0) ? -h.y : h.y;
      if (mis || ay <= th) begin
        mw[m][h.idx][0] = sat(mw[m][h.idx][0] + (out ? 1 : -1));
        for (int i = 1; i <= 8; i++)
          mw[m][h.idx][i] = sat(mw[m][h.idx][i] + ((h.g[i-1] == out) ? 1 : -1));
      end
    end
    if (mis) begin
      mghr[m] = {h.g[6:0], out};
      mcnt[m] = 0;
      nrec[m]++;
    end else begin
      if (pop) begin
        for (int j = 0; j < 7; j++) mq[m][j] = mq[m][j+1];
        mcnt[m]--;
      end
      if (acc) begin
        e.idx = idx; e.g = mghr[m]; e.y = y; e.pred = pred;
        mq[m][mcnt[m]] = e;
        mcnt[m]++;
        mghr[m] = {mghr[m][6:0], pred};
      end
    end
    nxt_pv[m] = acc;
    nxt_pt[m] = acc && pred;
  endtask

  task automatic cyc(input bit req, input logic [31:0] pc, input bit fb, input bit out);
    req_v = req; req_pc = pc; fb_v = fb; fb_out = out;
    for (int m = 0; m < 2; m++) model_step(m, req, pc, fb, out);
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      exp_pv[m] = nxt_pv[m];
      exp_pt[m] = nxt_pt[m];
    end
  endtask

  task automatic reset_checks(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_ready"}, m, int'(rdy[m]), 1);
      chk({tag, "_pvalid"}, m, int'(pv[m]), 0);
      chk({tag, "_ptaken"}, m, int'(pt[m]), 0);
      chk({tag, "_recover"}, m, int'(rec[m]), 0);
      chk({tag, "_fberr"}, m, int'(fbe[m]), 0);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        chk("ready", m, int'(rdy[m]), int'(exp_rdy[m]));
        chk("pred_valid", m, int'(pv[m]), int'(exp_pv[m]));
        chk("pred_taken", m, int'(pt[m]), int'(exp_pt[m]));
        chk("fb_error", m, int'(fbe[m]), int'(exp_fbe[m]));
        chk("recover", m, int'(rec[m]), int'(exp_rec[m]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g_save, hg;
    int         hidx, hbias;
    bit         o;

    rst = 1'b1; req_v = 0; fb_v = 0; fb_out = 0; req_pc = '0;
    model_reset();
    #2;
    reset_checks("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // First branch: idx 0x04, y = 0 -> TAKEN, one entry, GHR = 0x01.
    cyc(1, 32'h0040_0010, 0, 0);
    chk("first_pvalid", 0, int'(pv[0]), 1);
    chk("first_ptaken", 0, int'(pt[0]), 1);
    chk("first_ghr", 0, int'(mghr[0]), 8'h01);
    chk("first_count", 0, mcnt[0], 1);
    chk("first_idx", 0, mq[0][0].idx, 4);
    chk("first_y", 0, mq[0][0].y, 0);
    cyc(0, 32'h0, 1, 1);
    for (int k = 0; k < 19; k++) begin
      cyc(1, 32'h0040_0010, 0, 0);
      cyc(0, 32'h0, 1, 1);
    end
    // GHR saturates to 0xFF after 8; row 0xFB then trains 4x (y 0,9,18,27) or 12x (dut1).
    chk("loop_ghr", 0, int'(mghr[0]), 8'hFF);
    chk("loop_bias", 0, mw[0][8'hFB][0], 4);
    chk("loop_bias", 1, mw[1][8'hFB][0], 12);
    chk("loop_norecover", 0, nrec[0], 0);

    // Fill the FIFO; a fifth request is ignored.
    for (int k = 0; k < 4; k++) cyc(1, 32'h0040_0100 + 32'(k * 8), 0, 0);
    chk("full_ready", 0, int'(rdy[0]), 0);
    g_save = mghr[0];
    cyc(1, 32'h0040_0200, 0, 0);
    chk("full_pvalid", 0, int'(pv[0]), 0);
    chk("full_ghr_hold", 0, int'(mghr[0]), int'(g_save));
    chk("full_count", 0, mcnt[0], 4);
    cyc(0, 32'h0, 1, mq[0][0].pred);
    chk("pop_ready", 0, int'(rdy[0]), 1);
    chk("pop_count", 0, mcnt[0], 3);

    // Mispredict on the head with a same-cycle request that must be dropped.
    hg = mq[0][0].g; hidx = mq[0][0].idx; hbias = mw[0][hidx][0];
    o = ~mq[0][0].pred;
    cyc(1, 32'h0040_0300, 1, o);
    chk("mis_pvalid", 0, int'(pv[0]), 0);
    chk("mis_count", 0, mcnt[0], 0);
    chk("mis_ghr", 0, int'(mghr[0]), int'({hg[6:0], o}));
    chk("mis_bias", 0, mw[0][hidx][0], sat(hbias + (o ? 1 : -1)));
    chk("mis_nrec", 0, nrec[0], 1);

    // Full FIFO with simultaneous correct feedback still accepts the request.
    for (int k = 0; k < 4; k++) cyc(1, 32'h0040_0400 + 32'(k * 4), 0, 0);
    cyc(1, 32'h0040_0500, 1, mq[0][0].pred);
    chk("pushpop_pvalid", 0, int'(pv[0]), 1);
    chk("pushpop_count", 0, mcnt[0], 4);

    // Drain, then feedback against an empty FIFO.
    for (int k = 0; k < 8 && mcnt[0] > 0; k++) cyc(0, 32'h0, 1, mq[0][0].pred);
    chk("drain_count", 0, mcnt[0], 0);
    g_save = mghr[0];
    cyc(0, 32'h0, 1, 1);
    chk("empty_fberr", 0, int'(fbe[0]), 1);
    chk("empty_ghr_hold", 0, int'(mghr[0]), int'(g_save));
    cyc(0, 32'h0, 0, 0);

    // Asynchronous reset mid-stream with a prediction in flight.
    cyc(1, 32'h0040_0600, 0, 0);
    cyc(1, 32'h0040_0604, 0, 0);
    chk("pre_rst_pvalid", 0, int'(pv[0]), 1);
    rst = 1'b1; req_v = 0; fb_v = 0;
    model_reset();
    #1;
    reset_checks("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 32'h0040_0010, 0, 0);
    chk("post_rst_ptaken", 0, int'(pt[0]), 1);
    chk("post_rst_y", 0, mq[0][0].y, 0);
    cyc(0, 32'h0, 1, 1);

    // Saturation: dut1 always trains, so row 0xFB climbs to +127 and row 0x04 falls to -128.
    for (int k = 0; k < 300; k++) begin
      cyc(1, 32'h0040_0010, 0, 0);
      cyc(0, 32'h0, 1, 1);
    end
    chk("sat_hi_bias", 1, mw[1][8'hFB][0], 127);
    chk("sat_hi_w1", 1, mw[1][8'hFB][1], 127);
    for (int k = 0; k < 300; k++) begin
      cyc(1, 32'h0040_0010, 0, 0);
      cyc(0, 32'h0, 1, 0);
    end
    chk("sat_lo_bias", 1, mw[1][8'h04][0], -128);
    chk("sat_lo_w1", 1, mw[1][8'h04][1], 127);
    cyc(0, 32'h0, 0, 0);
    cyc(0, 32'h0, 0, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
